vreg_wb_arbiter: RTL

//  Shares the single write port of the 8-entry vector register file between two

---
 rtl/vreg_wb_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/vreg_wb_arbiter.sv
// Purpose: round-robin arbiter sharing the vector register file write port between the ALU and the load unit, plus a pending-write scoreboard.
// Latency: 2 edges from accept to register-file update (grant edge, then commit edge); hazard is combinational from registered busy.
// Backpressure: one request is accepted in every cycle with any valid; the losing requester sees ready=0 and holds its request.
module vreg_wb_arbiter #(
  parameter int N    = 192,
  parameter int NREG = 8,
  parameter int RW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_rd,
  input  logic [N-1:0]    alu_wd,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [RW-1:0]   mem_rd,
  input  logic [N-1:0]    mem_wd,
  output logic            rf_wr_enable,
  output logic [RW-1:0]   rf_rd,
  output logic [N-1:0]    rf_wd,
  input  logic            mark_valid,
  input  logic [RW-1:0]   mark_rd,
  input  logic [RW-1:0]   chk_rs1,
  input  logic [RW-1:0]   chk_rs2,
  input  logic [RW-1:0]   chk_rs3,
  input  logic [RW-1:0]   chk_rd,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            err_oor
);

  // One extra bit so NREG itself is representable when compared against an index.
  localparam logic [RW:0] NREG_W = (RW+1)'(NREG);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

  src_t          rr_last;
  logic          grant_alu;
  logic          grant_mem;
  logic [RW-1:0] sel_rd;
  logic [N-1:0]  sel_wd;
  logic          sel_in_range;

  // Round-robin grant: a lone requester always wins, on contention the one not served last wins.
  always_comb begin
    grant_alu    = alu_valid & (~mem_valid | (rr_last == SRC_MEM));
    grant_mem    = mem_valid & (~alu_valid | (rr_last == SRC_ALU));
    sel_rd       = grant_mem ? mem_rd : alu_rd;
    sel_wd       = grant_mem ? mem_wd : alu_wd;
    sel_in_range = ({1'b0, sel_rd} < NREG_W);
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Remember the last granted source; holds while idle so fairness survives gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= SRC_MEM;
    end else if (grant_alu) begin
      rr_last <= SRC_ALU;
    end else if (grant_mem) begin
      rr_last <= SRC_MEM;
    end
  end

  // Register the granted write; out-of-range indices complete the handshake but are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_enable <= 1'b0;
      rf_rd        <= '0;
      rf_wd        <= '0;
      err_oor      <= 1'b0;
    end else begin
      rf_wr_enable <= (grant_alu | grant_mem) & sel_in_range;
      err_oor      <= (grant_alu | grant_mem) & ~sel_in_range;
      if ((grant_alu | grant_mem) & sel_in_range) begin
        rf_rd <= sel_rd;
        rf_wd <= sel_wd;
      end
    end
  end

  // Scoreboard: a new mark beats a commit to the same register, since it is the newer pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (mark_valid && (mark_rd == RW'(r))) begin
          busy[r] <= 1'b1;
        end else if (rf_wr_enable && (rf_rd == RW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Hazard from registered busy only; matching against in-range r makes out-of-range indices never stall.
  always_comb begin
    hazard = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (busy[r] && ((chk_rs1 == RW'(r)) || (chk_rs2 == RW'(r)) ||
                      (chk_rs3 == RW'(r)) || (chk_rd == RW'(r)))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule
